rns_horner_mod_ctrl: RTL

- Sequencer that reduces a multi-digit unsigned number, streamed MSB-digit first, to its residue modulo MODULUS (default 47).
- Uses Horner evaluation, one digit per cycle: acc <- (acc*K + d) mod M, where K = RADIX mod M.
- Sits in front of the per-modulus RNS channels; it feeds each channel its residue and owns the shared constant-multiply LUT for that channel.

---
 rtl/rns_pkg.sv | 18 +
 rtl/mod_const_mul.sv | 26 ++
 rtl/rns_horner_mod_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rns_pkg.sv
// rtl/rns_pkg.sv - shared defaults, state type and radix helpers for the RNS front end
package rns_pkg;

  localparam int MODULUS_DEF = 47;
  localparam int DW_DEF      = 6;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} horner_state_t;

  function automatic int const_radix_mod(input int m, input int dw);
    return (1 << dw) % m;
  endfunction

  // A single conditional subtract only reduces correctly while the radix stays below 2*M.
  function automatic bit radix_ok(input int m, input int dw);
    return ((1 << dw) < 2 * m) && (m >= 2);
  endfunction

endpackage

// File: rtl/mod_const_mul.sv
// rtl/mod_const_mul.sv - constant multiply modulo MODULUS as a lookup table
module mod_const_mul #(
  parameter int MODULUS = 47,
  parameter int DW      = 6,
  parameter int K       = 17
) (
  input  logic [DW-1:0] a,
  output logic [DW-1:0] y
);

  typedef logic [2**DW-1:0][DW-1:0] lut_t;

  // Every index is filled, including a >= MODULUS, so the table is total.
  function automatic lut_t build_lut();
    lut_t t;
    for (int i = 0; i < 2**DW; i++) begin
      t[i] = DW'((i * K) % MODULUS);
    end
    return t;
  endfunction

  localparam lut_t LUT = build_lut();

  assign y = LUT[a];

endmodule

// File: rtl/rns_horner_mod_ctrl.sv
// rtl/rns_horner_mod_ctrl.sv - Horner residue sequencer, one MSB-first digit per cycle
import rns_pkg::*;

module rns_horner_mod_ctrl #(
  parameter int MODULUS    = MODULUS_DEF,
  parameter int DW         = DW_DEF,
  parameter int K          = const_radix_mod(MODULUS, DW),
  parameter int MAX_DIGITS = 32,
  parameter int CW         = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_last,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] res,
  output logic          res_err,
  output logic [CW-1:0] res_ndig,
  output logic          res_valid,
  input  logic          res_ready
);

  if (!radix_ok(MODULUS, DW)) begin : g_bad_radix
    $error("rns_horner_mod_ctrl: radix 2**DW must be below 2*MODULUS");
  end
  if (MAX_DIGITS >= (1 << CW) || MAX_DIGITS < 1) begin : g_bad_cw
    $error("rns_horner_mod_ctrl: CW cannot hold MAX_DIGITS");
  end

  localparam logic [DW-1:0] M_W   = DW'(MODULUS);
  localparam logic [CW-1:0] MAX_W = CW'(MAX_DIGITS);

  horner_state_t state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ndig_q, ndig_d;

  logic [DW-1:0] dr, acc_eff, p, acc_next;
  logic [DW:0]   s;
  logic [CW-1:0] cnt_inc;
  logic          accept, term;

  mod_const_mul #(.MODULUS(MODULUS), .DW(DW), .K(K)) u_mul (
    .a (acc_eff),
    .y (p)
  );

  assign dr       = (din >= M_W) ? din - M_W : din;
  assign acc_eff  = (state_q == ACCUM) ? acc_q : '0;
  assign s        = {1'b0, p} + {1'b0, dr};
  assign acc_next = (s >= {1'b0, M_W}) ? DW'(s - {1'b0, M_W}) : s[DW-1:0];
  assign cnt_inc  = cnt_q + CW'(1);
  assign accept   = din_valid & din_ready;
  assign term     = din_last | (cnt_inc == MAX_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ndig_q  <= ndig_d;
    end
  end

  // IDLE and ACCUM share one path: cnt is 0 and acc_eff is 0 whenever IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    ndig_d  = ndig_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          if (term) begin
            state_d = DONE;
            res_d   = acc_next;
            ndig_d  = cnt_inc;
            err_d   = ~din_last;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    din_ready = (state_q != DONE);
    res_valid = (state_q == DONE);
    res       = res_q;
    res_err   = err_q;
    res_ndig  = ndig_q;
  end

endmodule
